regfile_writeback: RTL

Write-back stage that owns the register file's single write port. It accepts single-cycle ALU results and in-order responses for multi-cycle loads, and arbitrates between them onto one registered write (we/rd/data) per cycle. It tracks outstanding load destinations in a small in-order queue and exports a pending-register scoreboard that decode uses to stall on load-use hazards.

---
 rtl/regfile_writeback_if.sv | 38 +++
 rtl/regfile_writeback.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_if.sv
// Bundle of ALU result, load issue/response and register-file write signals
// exchanged between the pipeline and the write-back stage.
interface regfile_writeback_if;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        o_alu_ready;
    logic        i_ld_issue;
    logic [4:0]  i_ld_rd;
    logic        o_ld_issue_ready;
    logic        i_ld_resp_valid;
    logic [31:0] i_ld_resp_data;
    logic        o_we;
    logic [4:0]  o_write_register;
    logic [31:0] o_write_data;
    logic [31:0] o_pending;
    logic        o_err;

    // Pipeline side: produces results, issues loads, returns load data
    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_ld_issue, i_ld_rd,
        output i_ld_resp_valid, i_ld_resp_data,
        input  o_alu_ready, o_ld_issue_ready,
        input  o_we, o_write_register, o_write_data,
        input  o_pending, o_err
    );

    // Write-back stage side
    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_ld_issue, i_ld_rd,
        input  i_ld_resp_valid, i_ld_resp_data,
        output o_alu_ready, o_ld_issue_ready,
        output o_we, o_write_register, o_write_data,
        output o_pending, o_err
    );
endinterface

// File: rtl/regfile_writeback.sv
// Write-back stage: arbitrates load responses (priority) and ALU results onto
// the single registered register-file write port, tracks outstanding load
// destinations in an in-order queue and exports a pending-register scoreboard.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    regfile_writeback_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // Load destination queue; head is read combinationally on a response
    logic [4:0]    q_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic          we_reg;
    logic [4:0]    write_register_reg;
    logic [31:0]   write_data_reg;
    logic          err_reg;

    logic          issue_fire;
    logic          pop_fire;
    logic          empty_resp;
    logic          alu_ready;
    logic          alu_fire;
    logic [4:0]    head_rd;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic          sel_valid;
    logic [DEPTH-1:0] slot_valid;
    logic [31:0]   pending_next;

    // Handshakes: issue only when not full (no bypass), a response pops only
    // when something is queued, and a popping response blocks the ALU.
    assign issue_fire = bus.i_ld_issue && (count_reg < FULL_COUNT);
    assign pop_fire   = bus.i_ld_resp_valid && (count_reg != '0);
    assign empty_resp = bus.i_ld_resp_valid && (count_reg == '0);
    assign alu_ready  = !pop_fire;
    assign alu_fire   = bus.i_alu_valid && alu_ready;
    assign head_rd    = q_mem[rd_ptr_reg];

    // Source select for the write port: load response wins over the ALU
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = bus.i_alu_rd;
        sel_data  = bus.i_alu_data;
        if (pop_fire) begin
            sel_valid = 1'b1;
            sel_rd    = head_rd;
            sel_data  = bus.i_ld_resp_data;
        end else if (alu_fire) begin
            sel_valid = 1'b1;
        end
    end

    // A slot is live when its distance from the head is below the count
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [AW-1:0] SLOT = AW'(gi);
            logic [AW-1:0] offset;
            assign offset         = SLOT - rd_ptr_reg;
            assign slot_valid[gi] = ({1'b0, offset} < count_reg);
        end
    endgenerate

    // Scoreboard: OR of one-hot decodes of every live entry, x0 never pending
    always_comb begin
        pending_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) begin
                pending_next[q_mem[i]] = 1'b1;
            end
        end
        pending_next[0] = 1'b0;
    end

    // Queue storage write; contents need no reset since count gates them
    always_ff @(posedge i_clk) begin
        if (issue_fire) begin
            q_mem[wr_ptr_reg] <= bus.i_ld_rd;
        end
    end

    // Queue pointers and occupancy; reset drops all outstanding loads
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (issue_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (issue_fire && !pop_fire) begin
                count_reg <= count_reg + 1'b1;
            end else if (!issue_fire && pop_fire) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Registered write port; address/data hold when nothing is written
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            we_reg             <= 1'b0;
            write_register_reg <= '0;
            write_data_reg     <= '0;
        end else if (sel_valid && (sel_rd != 5'd0)) begin
            we_reg             <= 1'b1;
            write_register_reg <= sel_rd;
            write_data_reg     <= sel_data;
        end else begin
            we_reg             <= 1'b0;
        end
    end

    // Sticky error for a response with nothing outstanding
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_reg <= 1'b0;
        end else if (empty_resp) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.o_alu_ready      = alu_ready;
    assign bus.o_ld_issue_ready = (count_reg < FULL_COUNT);
    assign bus.o_we             = we_reg;
    assign bus.o_write_register = write_register_reg;
    assign bus.o_write_data     = write_data_reg;
    assign bus.o_pending        = pending_next;
    assign bus.o_err            = err_reg;
endmodule
